imm_gen_pipe: RTL and testbench

//  Registered, XLEN-parametrised RV immediate generator for the decode stage.

---
 rtl/imm_gen_pipe.sv | 169 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator for decode, with a 2-entry skid buffer
// so in_ready depends only on held state, never on out_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] F_R    = 3'b000;
    localparam logic [2:0] F_I    = 3'b001;
    localparam logic [2:0] F_S    = 3'b010;
    localparam logic [2:0] F_B    = 3'b011;
    localparam logic [2:0] F_U    = 3'b100;
    localparam logic [2:0] F_J    = 3'b101;
    localparam logic [2:0] F_NONE = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } ent_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, nxt;
    ent_t   out_q, skid_q, dec;
    logic   ovalid_q, irdy_q;
    logic   acc, xfer;
    logic   ld_out, ld_skid, ld_fwd;

    logic [6:0]        op;
    logic [2:0]        f3;
    logic              is_shift;
    logic [5:0]        shamt;
    logic signed [31:0] s32;

    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];

    always_comb begin
        dec      = '0;
        dec.tag  = in_tag;
        s32      = '0;
        is_shift = 1'b0;
        shamt    = {1'b0, in_instr[24:20]};
        case (op)
            7'b0110011, 7'b0111011: dec.fmt = F_R;
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.fmt = F_I;
                s32     = 32'(signed'(in_instr[31:20]));
            end
            7'b0010011, 7'b0011011: begin
                dec.fmt  = F_I;
                s32      = 32'(signed'(in_instr[31:20]));
                is_shift = (f3 == 3'b001) || (f3 == 3'b101);
                // Only RV64 OP-IMM shifts use the 6-bit shamt; *W forms stay 5-bit
                if (op == 7'b0010011 && XLEN == 64)
                    shamt = in_instr[25:20];
            end
            7'b0100011: begin
                dec.fmt = F_S;
                s32     = 32'(signed'({in_instr[31:25], in_instr[11:7]}));
            end
            7'b1100011: begin
                dec.fmt = F_B;
                s32     = 32'(signed'({in_instr[31], in_instr[7],
                                       in_instr[30:25], in_instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = F_U;
                s32     = signed'({in_instr[31:12], 12'b0});
            end
            7'b1101111: begin
                dec.fmt = F_J;
                s32     = 32'(signed'({in_instr[31], in_instr[19:12],
                                       in_instr[20], in_instr[30:21], 1'b0}));
            end
            default: begin
                dec.fmt = F_NONE;
                dec.ill = 1'b1;
            end
        endcase
        dec.imm = is_shift ? XLEN'(shamt) : XLEN'(s32);
    end

    assign in_ready  = irdy_q;
    assign out_valid = ovalid_q;
    assign acc       = in_valid & irdy_q & ~flush;
    assign xfer      = ovalid_q & out_ready;

    always_comb begin
        nxt     = state_q;
        ld_out  = 1'b0;
        ld_skid = 1'b0;
        ld_fwd  = 1'b0;
        unique case (state_q)
            EMPTY: if (acc) begin
                nxt    = ONE;
                ld_out = 1'b1;
            end
            ONE: begin
                if (acc && xfer) begin
                    ld_out = 1'b1;
                end else if (acc) begin
                    nxt     = FULL;
                    ld_skid = 1'b1;
                end else if (xfer) begin
                    nxt = EMPTY;
                end
            end
            FULL: if (xfer) begin
                nxt    = ONE;
                ld_fwd = 1'b1;
            end
            default: nxt = EMPTY;
        endcase
        // Flush wins over everything; held data stays put so outputs don't go X
        if (flush) begin
            nxt     = EMPTY;
            ld_out  = 1'b0;
            ld_skid = 1'b0;
            ld_fwd  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            out_q    <= '0;
            skid_q   <= '0;
            ovalid_q <= 1'b0;
            irdy_q   <= 1'b0;
        end else begin
            state_q  <= nxt;
            ovalid_q <= (nxt != EMPTY);
            irdy_q   <= (nxt != FULL);
            if (ld_out)
                out_q <= dec;
            else if (ld_fwd)
                out_q <= skid_q;
            if (ld_skid)
                skid_q <= dec;
        end
    end

    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.ill;
    assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=64/32 instances,
// plus backpressure, flush and mid-run reset sequences.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;

    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [7:0]  out_tag;

    logic        r32_ready, v32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [7:0]  tag32;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r32_ready),
        .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_tag(tag32)
    );

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  tag;
        logic [63:0] imm;
        logic [31:0] imm32;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t v[16];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " out_valid"}, 64'(out_valid), 64'd0);
        chk({nm, " in_ready"}, 64'(in_ready), 64'd0);
        chk({nm, " out_imm"}, out_imm, 64'd0);
        chk({nm, " out_fmt"}, 64'(out_fmt), 64'd0);
        chk({nm, " out_illegal"}, 64'(out_illegal), 64'd0);
        chk({nm, " out_tag"}, 64'(out_tag), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        v[0]  = '{32'hFFF00093, 8'h01, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'b001, 1'b0};
        v[1]  = '{32'hFE112E23, 8'h02, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'b010, 1'b0};
        v[2]  = '{32'h4010D093, 8'h03, 64'h1,                32'h1,        3'b001, 1'b0};
        v[3]  = '{32'h800002B7, 8'h04, 64'hFFFFFFFF80000000, 32'h80000000, 3'b100, 1'b0};
        v[4]  = '{32'h0000007F, 8'hA5, 64'h0,                32'h0,        3'b111, 1'b1};
        v[5]  = '{32'h003100B3, 8'h06, 64'h0,                32'h0,        3'b000, 1'b0};
        v[6]  = '{32'hFE000EE3, 8'h07, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'b011, 1'b0};
        v[7]  = '{32'h001000EF, 8'h08, 64'h800,              32'h800,      3'b101, 1'b0};
        v[8]  = '{32'h03F09093, 8'h09, 64'd63,               32'd31,       3'b001, 1'b0};
        v[9]  = '{32'h41F0D09B, 8'h0A, 64'd31,               32'd31,       3'b001, 1'b0};
        v[10] = '{32'h7FF12083, 8'h0B, 64'h7FF,              32'h7FF,      3'b001, 1'b0};
        v[11] = '{32'h12345097, 8'h0C, 64'h12345000,         32'h12345000, 3'b100, 1'b0};
        v[12] = '{32'h00000073, 8'h0D, 64'h0,                32'h0,        3'b001, 1'b0};
        v[13] = '{32'h8000009B, 8'h0E, 64'hFFFFFFFFFFFFF800, 32'hFFFFF800, 3'b001, 1'b0};
        v[14] = '{32'h0000003B, 8'h0F, 64'h0,                32'h0,        3'b000, 1'b0};
        v[15] = '{32'h00000057, 8'h10, 64'h0,                32'h0,        3'b111, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_instr = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset in_ready", 64'(in_ready), 64'd1);
        chk("post-reset out_valid", 64'(out_valid), 64'd0);

        // Streamed decode table, one per cycle with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = v[i].instr;
            in_tag   = v[i].tag;
            @(posedge clk); #1;
            chk($sformatf("v%0d valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d imm", i), out_imm, v[i].imm);
            chk($sformatf("v%0d fmt", i), 64'(out_fmt), 64'(v[i].fmt));
            chk($sformatf("v%0d illegal", i), 64'(out_illegal), 64'(v[i].ill));
            chk($sformatf("v%0d tag", i), 64'(out_tag), 64'(v[i].tag));
            chk($sformatf("v%0d imm32", i), 64'(imm32), 64'(v[i].imm32));
            chk($sformatf("v%0d fmt32", i), 64'(fmt32), 64'(v[i].fmt));
        end
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain valid", 64'(out_valid), 64'd0);
        chk("idle tag hold", 64'(out_tag), 64'h10);
        chk("idle fmt hold", 64'(out_fmt), 64'd7);

        // Backpressure: tags 1,2 fill the block, 3 stalls, then drain in order
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFFF00093; in_tag = 8'd1;
        @(posedge clk); #1;
        chk("bp t1 out", 64'(out_tag), 64'd1);
        chk("bp t1 in_ready", 64'(in_ready), 64'd1);
        @(negedge clk) in_tag = 8'd2;
        @(posedge clk); #1;
        chk("bp full in_ready", 64'(in_ready), 64'd0);
        chk("bp hold tag", 64'(out_tag), 64'd1);
        @(negedge clk) in_tag = 8'd3;
        @(posedge clk); #1;
        chk("bp stall tag", 64'(out_tag), 64'd1);
        chk("bp stall imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("bp stall in_ready", 64'(in_ready), 64'd0);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp out2 tag", 64'(out_tag), 64'd2);
        chk("bp out2 valid", 64'(out_valid), 64'd1);
        chk("bp out2 in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp out3 tag", 64'(out_tag), 64'd3);
        chk("bp out3 valid", 64'(out_valid), 64'd1);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp empty", 64'(out_valid), 64'd0);

        // Flush while FULL with an instruction on offer
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 8'd4;
        @(posedge clk);
        @(negedge clk) in_tag = 8'd5;
        @(posedge clk); #1;
        chk("fl full in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b1; in_tag = 8'd9;
        @(posedge clk); #1;
        chk("fl out_valid", 64'(out_valid), 64'd0);
        chk("fl in_ready", 64'(in_ready), 64'd1);
        chk("fl tag hold", 64'(out_tag), 64'd4);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("fl nothing taken", 64'(out_valid), 64'd0);

        // Reset mid-operation clears outputs
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'h0000007F; in_tag = 8'hA5;
        @(posedge clk); #1;
        chk("rs tag", 64'(out_tag), 64'hA5);
        chk("rs illegal", 64'(out_illegal), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset("midreset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midreset in_ready", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
